// File: rtl/if_id_fetch_if.sv
// Fetch-stage bus: PC in, PC stall out, instruction-memory handshake,
// hazard/flush controls and the IF/ID pipeline register contents.
interface if_id_fetch_if;
    logic [31:0] pc_i;
    logic        pc_stall_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        stall_i;
    logic        flush_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        misalign_o;

    // Surrounding pipeline / memory side.
    modport master (
        output pc_i, imem_ack_i, imem_data_i, stall_i, flush_i,
        input  pc_stall_o, imem_req_o, imem_addr_o, if_id_valid_o,
               if_id_pc_o, if_id_pc4_o, if_id_instr_o, misalign_o
    );

    // Fetch stage side.
    modport slave (
        input  pc_i, imem_ack_i, imem_data_i, stall_i, flush_i,
        output pc_stall_o, imem_req_o, imem_addr_o, if_id_valid_o,
               if_id_pc_o, if_id_pc4_o, if_id_instr_o, misalign_o
    );
endinterface

// File: rtl/if_id_fetch.sv
// Fetch stage: issues imem reads at pc_i, absorbs variable memory latency,
// buffers one instruction across hazard stalls, and fills the IF/ID register.
//
// state | meaning
// FETCH | request outstanding at pc_i (when aligned), waiting for ack
// HOLD  | one fetched instruction buffered while decode is stalled
// HALT  | misaligned pc seen; waits for flush or reset
module if_id_fetch #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter logic [31:0] PC_INC    = 32'd4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    if_id_fetch_if.slave  bus
);

    typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;
    typedef enum logic [1:0] {LD_NONE, LD_BUBBLE, LD_MEM, LD_BUF} load_t;

    state_t      state, state_n;
    load_t       load_sel;
    logic        capture;
    logic        misalign_q, misalign_n;
    logic        req_c, pc_stall_c;
    logic        aligned;

    logic        valid_q;
    logic [31:0] pc_q, pc4_q, instr_q;
    logic [31:0] buf_pc, buf_instr;

    assign aligned = (bus.pc_i[1:0] == 2'b00);

    // State, IF/ID register, one-deep buffer and sticky misalign flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= FETCH;
            misalign_q <= 1'b0;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            pc4_q      <= '0;
            instr_q    <= NOP_INSTR;
            buf_pc     <= '0;
            buf_instr  <= '0;
        end else begin
            state      <= state_n;
            misalign_q <= misalign_n;
            if (bus.flush_i) begin
                buf_pc    <= '0;
                buf_instr <= '0;
            end else if (capture) begin
                buf_pc    <= bus.pc_i;
                buf_instr <= bus.imem_data_i;
            end
            case (load_sel)
                LD_BUBBLE: begin
                    valid_q <= 1'b0;
                    pc_q    <= '0;
                    pc4_q   <= '0;
                    instr_q <= NOP_INSTR;
                end
                LD_MEM: begin
                    valid_q <= 1'b1;
                    pc_q    <= bus.pc_i;
                    pc4_q   <= bus.pc_i + PC_INC;
                    instr_q <= bus.imem_data_i;
                end
                LD_BUF: begin
                    valid_q <= 1'b1;
                    pc_q    <= buf_pc;
                    pc4_q   <= buf_pc + PC_INC;
                    instr_q <= buf_instr;
                end
                default: ;
            endcase
        end
    end

    // Next state, IF/ID load selection, request and PC stall.
    always_comb begin
        state_n    = state;
        load_sel   = LD_NONE;
        capture    = 1'b0;
        misalign_n = misalign_q;
        req_c      = 1'b0;
        pc_stall_c = 1'b1;
        if (bus.flush_i) begin
            // Redirect: squash everything, let the PC take the target.
            load_sel   = LD_BUBBLE;
            state_n    = FETCH;
            misalign_n = 1'b0;
            pc_stall_c = 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!aligned) begin
                        state_n    = HALT;
                        misalign_n = 1'b1;
                        if (!bus.stall_i) load_sel = LD_BUBBLE;
                    end else begin
                        req_c = 1'b1;
                        if (bus.imem_ack_i) begin
                            if (!bus.stall_i) begin
                                load_sel   = LD_MEM;
                                pc_stall_c = 1'b0;
                            end else begin
                                capture = 1'b1;
                                state_n = HOLD;
                            end
                        end else if (!bus.stall_i) begin
                            load_sel = LD_BUBBLE;
                        end
                    end
                end
                HOLD: begin
                    pc_stall_c = bus.stall_i;
                    if (!bus.stall_i) begin
                        load_sel = LD_BUF;
                        state_n  = FETCH;
                    end
                end
                HALT: begin
                    if (!bus.stall_i) load_sel = LD_BUBBLE;
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // Reset overrides the handshake: no request, PC held.
    assign bus.imem_req_o    = req_c & ~rst_i;
    assign bus.pc_stall_o    = pc_stall_c | rst_i;
    assign bus.imem_addr_o   = bus.pc_i;
    assign bus.if_id_valid_o = valid_q;
    assign bus.if_id_pc_o    = pc_q;
    assign bus.if_id_pc4_o   = pc4_q;
    assign bus.if_id_instr_o = instr_q;
    assign bus.misalign_o    = misalign_q;

endmodule

// File: tb/tb_if_id_fetch.sv
// Self-checking bench for if_id_fetch: directed scenarios plus random
// stimulus, compared against a behavioural model of the fetch stage.
module tb_if_id_fetch;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    if_id_fetch_if bus();

    if_id_fetch dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    // Reference model: what the IF/ID register should hold, whether a fetched
    // instruction is parked, and whether fetch is halted on a bad PC.
    logic        m_valid;
    logic [31:0] m_pc, m_pc4, m_instr;
    bit          m_parked;
    logic [31:0] m_park_pc, m_park_instr;
    bit          m_halted;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_pc4 = '0; m_instr = NOP;
        m_parked = 0; m_park_pc = '0; m_park_instr = '0; m_halted = 0;
    endtask

    task automatic model_bubble();
        m_valid = 1'b0; m_pc = '0; m_pc4 = '0; m_instr = NOP;
    endtask

    task automatic model_load(input logic [31:0] pc, input logic [31:0] ins);
        m_valid = 1'b1; m_pc = pc; m_pc4 = pc + 32'd4; m_instr = ins;
    endtask

    task automatic check_regs();
        check_val("valid", {31'b0, bus.if_id_valid_o}, {31'b0, m_valid});
        check_val("pc",    bus.if_id_pc_o,    m_pc);
        check_val("pc4",   bus.if_id_pc4_o,   m_pc4);
        check_val("instr", bus.if_id_instr_o, m_instr);
        check_val("misal", {31'b0, bus.misalign_o}, {31'b0, m_halted});
    endtask

    // One clock cycle: drive at negedge, check combinational outputs,
    // advance model at posedge, then check registered outputs.
    task automatic cycle(input logic [31:0] pc, input bit ack,
                         input logic [31:0] data, input bit stall,
                         input bit flush);
        bit exp_req, exp_pcs, aligned;
        @(negedge clk_i);
        bus.pc_i = pc; bus.imem_ack_i = ack; bus.imem_data_i = data;
        bus.stall_i = stall; bus.flush_i = flush;
        #1;
        aligned = (pc % 4) == 0;
        exp_req = !flush && !m_halted && !m_parked && aligned;
        if (flush)         exp_pcs = 0;
        else if (m_parked) exp_pcs = stall;
        else if (m_halted) exp_pcs = 1;
        else               exp_pcs = !(aligned && ack && !stall);
        check_val("req",      {31'b0, bus.imem_req_o}, {31'b0, exp_req});
        check_val("pc_stall", {31'b0, bus.pc_stall_o}, {31'b0, exp_pcs});
        check_val("addr",     bus.imem_addr_o, pc);
        @(posedge clk_i);
        if (flush) begin
            model_bubble(); m_parked = 0; m_halted = 0;
        end else if (m_halted) begin
            if (!stall) model_bubble();
        end else if (m_parked) begin
            if (!stall) begin
                model_load(m_park_pc, m_park_instr); m_parked = 0;
            end
        end else if (!aligned) begin
            m_halted = 1;
            if (!stall) model_bubble();
        end else if (ack) begin
            if (!stall) model_load(pc, data);
            else begin
                m_parked = 1; m_park_pc = pc; m_park_instr = data;
            end
        end else if (!stall) begin
            model_bubble();
        end
        #1;
        check_regs();
    endtask

    initial begin
        logic [31:0] rpc;
        bus.pc_i = '0; bus.imem_ack_i = 0; bus.imem_data_i = '0;
        bus.stall_i = 0; bus.flush_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_regs();
        check_val("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
        check_val("rst_pcs", {31'b0, bus.pc_stall_o}, 32'd1);

        // Load something real, then assert reset mid-cycle.
        @(negedge clk_i); rst_i = 0;
        cycle(32'h40, 1, 32'hAAAA0001, 0, 0);
        #2; rst_i = 1; #1;
        model_reset();
        check_regs();
        check_val("mid_rst_req", {31'b0, bus.imem_req_o}, 32'd0);
        check_val("mid_rst_pcs", {31'b0, bus.pc_stall_o}, 32'd1);

        // Zero-latency memory at 0, 4, 8.
        @(negedge clk_i); rst_i = 0;
        cycle(32'h0, 1, 32'h11111111, 0, 0);
        cycle(32'h4, 1, 32'h22222222, 0, 0);
        cycle(32'h8, 1, 32'h33333333, 0, 0);
        check_val("pc4_seq", bus.if_id_pc4_o, 32'h0000000C);

        // Three-cycle latency at 0x100.
        cycle(32'h100, 0, 32'h0, 0, 0);
        cycle(32'h100, 0, 32'h0, 0, 0);
        cycle(32'h100, 1, 32'hCAFE0100, 0, 0);
        check_val("lat_pc4", bus.if_id_pc4_o, 32'h104);

        // Ack under stall at 0x20, held two cycles, then released.
        cycle(32'h20, 1, 32'hBEEF0020, 1, 0);
        cycle(32'h20, 0, 32'h0, 1, 0);
        cycle(32'h20, 0, 32'h0, 0, 0);
        check_val("hold_instr", bus.if_id_instr_o, 32'hBEEF0020);

        // Flush while holding a buffered instruction, then fetch at 0x400.
        cycle(32'h30, 1, 32'hDEAD0030, 1, 0);
        cycle(32'h30, 0, 32'h0, 1, 1);
        cycle(32'h400, 1, 32'h00400400, 0, 0);
        check_val("after_flush", bus.if_id_pc_o, 32'h400);
        // Flush with stall and ack together: ack ignored.
        cycle(32'h404, 1, 32'h99999999, 1, 1);

        // Misaligned PC, halted for five cycles, recovered by flush.
        cycle(32'h102, 1, 32'h12345678, 0, 0);
        for (int i = 0; i < 5; i++) cycle(32'h102, 1, 32'h12345678, 0, 0);
        check_val("halt_misal", {31'b0, bus.misalign_o}, 32'd1);
        cycle(32'h200, 0, 32'h0, 0, 1);
        cycle(32'h200, 1, 32'h20020020, 0, 0);

        // PC wrap.
        cycle(32'hFFFFFFFC, 1, 32'h7777_7777, 0, 0);
        check_val("wrap_pc4", bus.if_id_pc4_o, 32'h00000000);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            rpc = {$urandom_range(0, 63), 2'b00};
            if ($urandom_range(0, 19) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 49) == 0) rpc = 32'hFFFFFFFC;
            cycle(rpc, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_fetch.md
Name: if_id_fetch

Overview:
Fetch stage between the PC register and the decode stage. Issues instruction-memory reads at the current PC and tolerates variable memory latency via a req/ack handshake. Delivers the fetched instruction into the IF/ID pipeline register. Drives the PC stall when fetch cannot advance, and handles hazard stalls, branch flushes and misaligned PCs.

Parameters:
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) loaded into IF/ID when nothing valid is available.
PC_INC, 32'd4, PC+increment published alongside each instruction.

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
pc_i  input  32  current PC from PC register
pc_stall_o  output  1  1 = PC register must hold its value
imem_req_o  output  1  read request to instruction memory
imem_addr_o  output  32  read address, equals pc_i
imem_ack_i  input  1  read data valid this cycle
imem_data_i  input  32  read data, valid when imem_ack_i=1
stall_i  input  1  hazard unit: hold IF/ID contents
flush_i  input  1  branch/jump taken: squash IF/ID and any buffered fetch
if_id_valid_o  output  1  IF/ID holds a real instruction
if_id_pc_o  output  32  PC of IF/ID instruction
if_id_pc4_o  output  32  if_id_pc_o + PC_INC (mod 2^32)
if_id_instr_o  output  32  IF/ID instruction
misalign_o  output  1  sticky: fetch halted on pc_i[1:0]!=0

Behaviour:
- States: FETCH, HOLD, HALT. Reset state is FETCH.
- Reset (asynchronous, while rst_i=1): state=FETCH. if_id_valid_o=0, if_id_pc_o=0, if_id_pc4_o=0, if_id_instr_o=NOP_INSTR. Buffer cleared, misalign_o=0. imem_req_o=0 and pc_stall_o=1 while rst_i=1.
- imem_req_o=1 only in FETCH, with rst_i=0, pc_i[1:0]==0 and flush_i=0. imem_addr_o=pc_i at all times.
- Memory is read-only with no side effects. Withdrawing req before ack is legal. Ack is only honoured when req=1 in the same cycle; 0-cycle latency (ack in the same cycle as req) is allowed.
- Bubble load: if_id_valid_o=0, if_id_instr_o=NOP_INSTR, if_id_pc_o=0, if_id_pc4_o=0.
- Priority each cycle: rst_i > flush_i > misalign > stall_i > normal.
- flush_i=1, any state:
  - IF/ID takes a bubble load.
  - Buffered instruction is discarded; state goes to FETCH; misalign_o is cleared.
  - pc_stall_o=0, so the PC loads the redirect target.
  - A concurrent ack is ignored.
- FETCH, pc_i[1:0]!=0, no flush: no request is issued. Next state is HALT with misalign_o=1. IF/ID takes a bubble load unless stall_i=1. pc_stall_o=1.
- HALT: pc_stall_o=1 and imem_req_o=0. IF/ID takes a bubble load when stall_i=0. The only exits are flush_i or rst_i.
- FETCH, ack=1, stall_i=0:
  - IF/ID loads {valid=1, pc_i, pc_i+PC_INC, imem_data_i}.
  - pc_stall_o=0, so the PC advances in the same cycle.
  - Stay in FETCH.
- FETCH, ack=1, stall_i=1:
  - Capture {pc_i, imem_data_i} into the buffer; go to HOLD.
  - pc_stall_o=1; IF/ID unchanged.
- FETCH, ack=0: pc_stall_o=1. If stall_i=0, IF/ID takes a bubble load; if stall_i=1, IF/ID is unchanged.
- HOLD: imem_req_o=0 and pc_stall_o=stall_i.
  - stall_i=1: IF/ID unchanged.
  - stall_i=0: IF/ID loads the buffer with valid=1, then go to FETCH. PC advances that cycle.
- pc_stall_o is combinational from state, ack, stall_i, flush_i and pc_i[1:0]. All IF/ID outputs are registered.
- Wrap-around: pc_i=32'hFFFFFFFC yields if_id_pc4_o=32'h00000000.
- At most one instruction is buffered. No fetch is issued while in HOLD.

Test Plan:
- Reset then zero-latency memory: assert rst_i mid-cycle. Outputs go to bubble values and req=0 immediately. Release rst_i with pc 0,4,8 and ack in the same cycle → IF/ID valid with pc 0,4,8 on consecutive edges, pc4 4,8,C, pc_stall_o=0 throughout.
- 3-cycle memory latency at pc=0x100, stall_i=0 → two bubble cycles with pc_stall_o=1, then IF/ID={1,0x100,0x104,data}.
- Ack at pc=0x20 while stall_i=1 for 2 cycles → IF/ID holds its old value, req=0 in HOLD. On stall release, IF/ID={1,0x20,0x24,data}; PC advances in that cycle only.
- Flush: flush_i in HOLD with a buffered instruction → IF/ID becomes a bubble, buffer is dropped, next fetch uses the new pc_i=0x400. Also drive flush_i=1 together with stall_i=1 and ack=1 → bubble, ack ignored.
- pc_i=0x102 → misalign_o=1, no req, pc_stall_o stays 1 for 5 cycles with bubbles. flush_i with pc_i=0x200 → misalign_o=0, fetch resumes.
- pc_i=0xFFFFFFFC with ack → if_id_pc4_o=0x00000000.
